imem_loader: RTL and testbench

Byte-stream program loader that fills instruction memory before the CPU runs. It receives a length-prefixed, checksummed byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit words, and issues one single-cycle write per word at consecutive word addresses starting at 0. While a load is in progress it asserts a hold that keeps the fetch path stalled. On completion it reports done and checksum status.

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_loader_if.sv | 41 ++++
 rtl/imem_loader_word_assembler.sv | 54 +++++
 rtl/imem_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the instruction-memory loader: FSM state encoding,
//   word geometry and reset constants.
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = 2;

    // Loader FSM encoding. Plain constants keep the encoding visible to
    // legacy tooling that probes the state register directly.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CNT_HI = 3'd1;
    localparam state_t ST_CNT_LO = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_CSUM   = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    localparam logic [7:0]  CSUM_RST  = 8'h00;
    localparam logic [15:0] COUNT_RST = 16'h0000;

    // A load is in progress in every state that consumes stream bytes.
    function automatic logic state_is_busy(input state_t s);
        return (s == ST_CNT_HI) || (s == ST_CNT_LO) ||
               (s == ST_DATA)   || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//   Bundles the loader's stream input, memory-write output and status.
//   slave  : loader side (consumes the stream, drives writes and status)
//   master : host/testbench side
//   Signals:
//     start      single-cycle load request
//     in_data    stream byte, in_valid/in_ready handshake
//     out_we     single-cycle instruction-memory write strobe
//     out_addr   word address (zero-extended to 32 bits)
//     out_wdata  word to write
//     out_busy   load in progress, out_hold mirrors it for the fetch stall
//     out_done   last load finished, out_err checksum mismatch on that load
// ---------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              out_we;
    logic [31:0]       out_addr;
    logic [WORD_W-1:0] out_wdata;
    logic              out_busy;
    logic              out_hold;
    logic              out_done;
    logic              out_err;

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, out_we, out_addr, out_wdata,
               out_busy, out_hold, out_done, out_err
    );

    modport master (
        output start, in_data, in_valid,
        input  in_ready, out_we, out_addr, out_wdata,
               out_busy, out_hold, out_done, out_err
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// loader_word_assembler
//   Packs accepted stream bytes big-endian into words. The first byte of a
//   word lands in the most significant position.
//   Ports:
//     clk, rst_n      clock, async active-low reset
//     clear           restart assembly at byte 0 (new load)
//     byte_valid      byte_in is accepted this cycle
//     byte_in         stream byte
//     word            assembled word, valid while word_complete=1
//     word_complete   the byte accepted this cycle finishes a word
// ---------------------------------------------------------------------------
module loader_word_assembler #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_complete
);

    localparam int BYTES = WORD_W / 8;
    localparam int IDX_W = $clog2(BYTES);

    // Only the leading BYTES-1 bytes are stored; the final byte is taken
    // straight from the input so the word is ready on its accepting edge.
    logic [WORD_W-9:0] shift_q;
    logic [IDX_W-1:0]  idx_q;

    logic last_byte;
    assign last_byte = (idx_q == IDX_W'(BYTES - 1));

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (clear) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (byte_valid) begin
            shift_q <= {shift_q[WORD_W-17:0], byte_in};
            idx_q   <= last_byte ? '0 : idx_q + 1'b1;
        end
    end

    assign word          = {shift_q, byte_in};
    assign word_complete = byte_valid && last_byte;

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Fills instruction memory from a length-prefixed, XOR-checksummed byte
//   stream: count_hi, count_lo, 4*N data bytes (MSB first), checksum byte.
//   One write per word at consecutive word addresses from 0, issued the cycle
//   after the word's last byte is accepted. Fetch is held while loading.
//   Ports:
//     clk     clock
//     rst_n   async active-low reset
//     bus     imem_loader_if.slave (stream in, memory write out, status)
//   Parameters:
//     ADDR_W  word-address width (memory depth 2^ADDR_W, addresses wrap)
//     WORD_W  instruction width
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int WORD_W = imem_loader_pkg::WORD_W
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);

    state_t state_q, state_d;

    logic [15:0]       words_left_q;   // count bytes, then words still to write
    logic [7:0]        csum_q;         // running XOR of count and data bytes
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [WORD_W-1:0] wdata_q;
    logic              done_q;
    logic              err_q;

    logic              busy;
    logic              accept;
    logic              start_ok;
    logic              data_byte;
    logic [WORD_W-1:0] asm_word;
    logic              asm_complete;
    logic [15:0]       count_full;

    assign busy      = state_is_busy(state_q);
    assign accept    = bus.in_valid && busy;
    assign start_ok  = bus.start && !busy;
    assign data_byte = accept && (state_q == ST_DATA);

    // Word count as it stands when count_lo is on the bus.
    assign count_full = {words_left_q[15:8], bus.in_data};

    loader_word_assembler #(
        .WORD_W (WORD_W)
    ) u_asm (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (start_ok),
        .byte_valid    (data_byte),
        .byte_in       (bus.in_data),
        .word          (asm_word),
        .word_complete (asm_complete)
    );

    // ---------------------------------------------------------------- FSM
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) state_d = ST_CNT_HI;
            end
            ST_CNT_HI: begin
                if (accept) state_d = ST_CNT_LO;
            end
            ST_CNT_LO: begin
                if (accept) state_d = (count_full == 16'd0) ? ST_CSUM : ST_DATA;
            end
            ST_DATA: begin
                if (asm_complete && (words_left_q == 16'd1)) state_d = ST_CSUM;
            end
            ST_CSUM: begin
                if (accept) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------- count and checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_left_q <= COUNT_RST;
            csum_q       <= CSUM_RST;
        end else if (start_ok) begin
            words_left_q <= COUNT_RST;
            csum_q       <= CSUM_RST;
        end else begin
            if (accept && (state_q == ST_CNT_HI)) begin
                words_left_q <= {bus.in_data, 8'h00};
            end else if (accept && (state_q == ST_CNT_LO)) begin
                words_left_q <= count_full;
            end else if (asm_complete) begin
                words_left_q <= words_left_q - 16'd1;
            end

            // The checksum byte itself is compared, not folded in.
            if (accept && (state_q != ST_CSUM)) begin
                csum_q <= csum_q ^ bus.in_data;
            end
        end
    end

    // ------------------------------------------------------ memory writes
    // The address counter steps after each write strobe, so during a strobe
    // it holds that word's index; it wraps modulo 2^ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            wdata_q <= '0;
            addr_q  <= '0;
        end else begin
            we_q <= asm_complete;
            if (asm_complete) begin
                wdata_q <= asm_word;
            end

            if (start_ok) begin
                addr_q <= '0;
            end else if (we_q) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (start_ok) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept && (state_q == ST_CSUM)) begin
            done_q <= 1'b1;
            err_q  <= (bus.in_data != csum_q);
        end
    end

    assign bus.in_ready  = busy;
    assign bus.out_we    = we_q;
    assign bus.out_addr  = 32'(addr_q);
    assign bus.out_wdata = wdata_q;
    assign bus.out_busy  = busy;
    assign bus.out_hold  = busy;
    assign bus.out_done  = done_q;
    assign bus.out_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader: a per-cycle vector table covering
//   nominal, bad-checksum, zero-length, start-while-busy and bytes offered in
//   IDLE/DONE, followed by hand-written gapped-valid and reset-mid-word runs.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    logic clk;
    logic rst_n;

    imem_loader_if #(.WORD_W(32)) bus ();

    imem_loader #(
        .ADDR_W (16),
        .WORD_W (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per cycle: inputs driven this cycle, and the outputs
    // expected to be visible during this cycle (before its rising edge).
    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        exp_ready;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    int n_vectors = 0;
    int n_miscompares = 0;

    logic [7:0]  stream_q[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic add(input logic s, input logic v, input logic [7:0] d,
                       input logic r, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic b, input logic dn,
                       input logic er);
        vec_t x;
        x.start = s;      x.valid = v;     x.data = d;
        x.exp_ready = r;  x.exp_we = we;   x.exp_addr = a;
        x.exp_wdata = wd; x.exp_busy = b;  x.exp_done = dn;
        x.exp_err = er;
        vecs.push_back(x);
    endtask

    // Shorthand for a busy cycle with no write expected.
    task automatic add_busy(input logic s, input logic [7:0] d,
                            input logic dn, input logic er);
        add(s, 1'b1, d, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, dn, er);
    endtask

    task automatic build_table();
        // Byte offered in IDLE is refused.
        add(0, 1, 8'hAA, 0, 0, 0, 0, 0, 0, 0);
        // Nominal load, checksum 0x28.
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        add_busy(0, 8'h00, 0, 0);
        add_busy(0, 8'h02, 0, 0);
        add_busy(0, 8'h12, 0, 0);
        add_busy(0, 8'h34, 0, 0);
        add_busy(0, 8'h56, 0, 0);
        add_busy(0, 8'h78, 0, 0);
        add(0, 1, 8'hDE, 1, 1, 32'd0, 32'h12345678, 1, 0, 0);
        add_busy(0, 8'hAD, 0, 0);
        add_busy(0, 8'hBE, 0, 0);
        add_busy(0, 8'hEF, 0, 0);
        add(0, 1, 8'h28, 1, 1, 32'd1, 32'hDEADBEEF, 1, 0, 0);
        // DONE: byte refused, status held.
        add(0, 1, 8'h55, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        // Bad checksum 0x29, with a start pulse during DATA that is ignored.
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        add_busy(0, 8'h00, 0, 0);
        add_busy(0, 8'h02, 0, 0);
        add_busy(0, 8'h12, 0, 0);
        add_busy(1, 8'h34, 0, 0);
        add_busy(0, 8'h56, 0, 0);
        add_busy(0, 8'h78, 0, 0);
        add(0, 1, 8'hDE, 1, 1, 32'd0, 32'h12345678, 1, 0, 0);
        add_busy(0, 8'hAD, 0, 0);
        add_busy(0, 8'hBE, 0, 0);
        add_busy(0, 8'hEF, 0, 0);
        add(0, 1, 8'h29, 1, 1, 32'd1, 32'hDEADBEEF, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1);
        // Zero length, good checksum 0x00; start during CNT_HI ignored.
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1);
        add_busy(1, 8'h00, 0, 0);
        add_busy(0, 8'h00, 0, 0);
        add_busy(0, 8'h00, 0, 0);
        add(0, 1, 8'h77, 0, 0, 0, 0, 0, 1, 0);
        // Zero length, bad checksum 0x01.
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        add_busy(0, 8'h00, 0, 0);
        add_busy(0, 8'h00, 0, 0);
        add_busy(0, 8'h01, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1);
        add(0, 1, 8'h01, 0, 0, 0, 0, 0, 1, 1);
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_ready));
            check($sformatf("v%0d out_we", i),   32'(bus.out_we),   32'(vecs[i].exp_we));
            check($sformatf("v%0d out_busy", i), 32'(bus.out_busy), 32'(vecs[i].exp_busy));
            check($sformatf("v%0d out_hold", i), 32'(bus.out_hold), 32'(vecs[i].exp_busy));
            check($sformatf("v%0d out_done", i), 32'(bus.out_done), 32'(vecs[i].exp_done));
            check($sformatf("v%0d out_err", i),  32'(bus.out_err),  32'(vecs[i].exp_err));
            if (vecs[i].exp_we) begin
                check($sformatf("v%0d out_addr", i),  bus.out_addr,  vecs[i].exp_addr);
                check($sformatf("v%0d out_wdata", i), bus.out_wdata, vecs[i].exp_wdata);
            end
            bus.start    = vecs[i].start;
            bus.in_valid = vecs[i].valid;
            bus.in_data  = vecs[i].data;
        end
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic load_nominal(input logic [7:0] csum);
        stream_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                     8'hDE, 8'hAD, 8'hBE, 8'hEF, csum};
    endtask

    // Streams stream_q (optionally with random valid gaps and a stray start
    // mid-load), records every write, then checks writes and final status.
    task automatic run_stream(input string tag, input bit gaps,
                              input bit start_mid, input logic exp_err);
        int idx = 0;
        int cycles = 0;
        bit v;
        wr_addr.delete();
        wr_data.delete();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (cycles < 300) begin
            if (bus.out_we) begin
                wr_addr.push_back(bus.out_addr);
                wr_data.push_back(bus.out_wdata);
            end
            if (bus.out_done) break;
            v = (idx < stream_q.size()) && !(gaps && ($urandom_range(0, 2) == 0));
            bus.in_valid = v;
            bus.in_data  = v ? stream_q[idx] : 8'hC3;
            bus.start    = start_mid && (idx == 6);
            if (v && bus.in_ready) idx++;
            @(negedge clk);
            cycles++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check({tag, " done before timeout"}, 32'(bus.out_done), 32'd1);
        check({tag, " bytes consumed"}, 32'(idx), 32'(stream_q.size()));
        check({tag, " write count"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check({tag, " write0 addr"}, wr_addr[0], 32'd0);
            check({tag, " write0 data"}, wr_data[0], 32'h12345678);
            check({tag, " write1 addr"}, wr_addr[1], 32'd1);
            check({tag, " write1 data"}, wr_data[1], 32'hDEADBEEF);
        end
        check({tag, " out_err"},  32'(bus.out_err),  32'(exp_err));
        check({tag, " out_busy"}, 32'(bus.out_busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " in_ready"},  32'(bus.in_ready), 32'd0);
        check({tag, " out_we"},    32'(bus.out_we),   32'd0);
        check({tag, " out_addr"},  bus.out_addr,      32'd0);
        check({tag, " out_wdata"}, bus.out_wdata,     32'd0);
        check({tag, " out_busy"},  32'(bus.out_busy), 32'd0);
        check({tag, " out_hold"},  32'(bus.out_hold), 32'd0);
        check({tag, " out_done"},  32'(bus.out_done), 32'd0);
        check({tag, " out_err"},   32'(bus.out_err),  32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        build_table();
        run_table();

        // Gapped valid plus a start pulse during DATA.
        load_nominal(8'h28);
        run_stream("gapped", 1'b1, 1'b1, 1'b0);

        // Reset after two data bytes of word 0.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        foreach (stream_q[i]) begin
            if (i < 4) begin
                bus.in_valid = 1'b1;
                bus.in_data  = stream_q[i];
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        check("midreset no write", 32'(bus.out_we), 32'd0);
        rst_n = 1'b1;

        // A fresh load after the aborted one starts again from address 0.
        run_stream("after_reset", 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
